// File: rtl/int_res_mem_arbiter_if.sv
// rtl/int_res_mem_arbiter_if.sv - requester and bank-side bus bundle for int_res_mem_arbiter
interface int_res_mem_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BANKS = 4
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      req_we;
    logic [NUM_REQ-1:0]      req_width;
    logic [NUM_REQ*16-1:0]   req_addr;
    logic [NUM_REQ*30-1:0]   req_wdata;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      rdata_valid;
    logic [29:0]             rdata;
    logic [NUM_BANKS-1:0]    bank_en;
    logic [NUM_BANKS-1:0]    bank_we;
    logic [NUM_BANKS*14-1:0] bank_addr;
    logic [NUM_BANKS*15-1:0] bank_wdata;
    logic [NUM_BANKS*15-1:0] bank_rdata;

    modport master (
        output req, req_we, req_width, req_addr, req_wdata, bank_rdata,
        input  gnt, rdata_valid, rdata, bank_en, bank_we, bank_addr, bank_wdata
    );
    modport slave (
        input  req, req_we, req_width, req_addr, req_wdata, bank_rdata,
        output gnt, rdata_valid, rdata, bank_en, bank_we, bank_addr, bank_wdata
    );
endinterface

// File: rtl/int_res_mem_arbiter.sv
// rtl/int_res_mem_arbiter.sv - round-robin arbiter onto the 4-bank int-res memory, splits double-width accesses
// Optional stall counters under INT_RES_ARB_STATS_EN.
module int_res_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BANK_WORDS = 14336,
    parameter int NUM_BANKS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    int_res_mem_arbiter_if.slave bus,
    output logic                 addr_err
`ifdef INT_RES_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] stall_cnt
`endif
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW = 14;
    localparam logic [16:0] TOP = 17'(NUM_BANKS * BANK_WORDS);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, win_nx;
    logic            lat_we, lat_dw;
    logic [15:0]     lat_addr;
    logic [29:0]     lat_wdata;
    logic [14:0]     lo_q;
    logic [BW-1:0]   lo_bank_q;
    logic            lo_oor_q;

    logic [16:0]     cur_addr;
    logic            cur_oor, acc;
    logic [BW-1:0]   cur_bank;
    logic [AW-1:0]   cur_baddr;
    logic [14:0]     cur_wword, hi_word;

    logic [NUM_REQ-1:0]      gnt_c, rv_c;
    logic [29:0]             rdata_c;
    logic [NUM_BANKS-1:0]    en_c, we_c;
    logic [NUM_BANKS*AW-1:0] addr_c;
    logic [NUM_BANKS*15-1:0] wdata_c;

    // Bank index is the count of bank bases the address has reached.
    function automatic logic [BW-1:0] bank_of(input logic [16:0] a);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 1; k < NUM_BANKS; k++)
            if (a >= 17'(k * BANK_WORDS)) b = BW'(k);
        return b;
    endfunction

    always_comb begin : arb_decode
        int idx;
        logic found;
        found  = 1'b0;
        win_nx = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                win_nx = PW'(idx);
            end
        end
        // High half lives at A+1 both while accessing it and while its read data returns.
        if (state == ACC_HI || (state == RESP && lat_dw))
            cur_addr = {1'b0, lat_addr} + 17'd1;
        else
            cur_addr = {1'b0, lat_addr};
        cur_oor   = (cur_addr >= TOP);
        cur_bank  = bank_of(cur_addr);
        cur_baddr = AW'(cur_addr - 17'(int'(cur_bank) * BANK_WORDS));
        cur_wword = (state == ACC_HI) ? lat_wdata[29:15] : lat_wdata[14:0];
    end

    always_comb begin
        state_nx = state;
        gnt_c    = '0;
        rv_c     = '0;
        rdata_c  = '0;
        en_c     = '0;
        we_c     = '0;
        addr_c   = '0;
        wdata_c  = '0;
        acc      = 1'b0;
        hi_word  = '0;
        case (state)
            IDLE: if (|bus.req) state_nx = ACC_LO;
            ACC_LO: begin
                gnt_c[ptr] = 1'b1;
                acc        = 1'b1;
                if (lat_dw)      state_nx = ACC_HI;
                else if (lat_we) state_nx = IDLE;
                else             state_nx = RESP;
            end
            ACC_HI: begin
                acc      = 1'b1;
                state_nx = lat_we ? IDLE : RESP;
            end
            RESP: begin
                rv_c[ptr] = 1'b1;
                hi_word   = cur_oor ? 15'd0 : bus.bank_rdata[int'(cur_bank)*15 +: 15];
                rdata_c   = lat_dw ? {hi_word, lo_q} : {{15{hi_word[14]}}, hi_word};
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (acc && !cur_oor) begin
            en_c[cur_bank]                  = 1'b1;
            we_c[cur_bank]                  = lat_we;
            addr_c[int'(cur_bank)*AW +: AW] = cur_baddr;
            if (lat_we) wdata_c[int'(cur_bank)*15 +: 15] = cur_wword;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PW'(NUM_REQ - 1);
            lat_we    <= 1'b0;
            lat_dw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lo_q      <= '0;
            lo_bank_q <= '0;
            lo_oor_q  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |bus.req) begin
                ptr       <= win_nx;
                lat_we    <= bus.req_we[win_nx];
                lat_dw    <= bus.req_width[win_nx];
                lat_addr  <= bus.req_addr[int'(win_nx)*16 +: 16];
                lat_wdata <= bus.req_wdata[int'(win_nx)*30 +: 30];
            end
            if (state == ACC_LO) begin
                lo_bank_q <= cur_bank;
                lo_oor_q  <= cur_oor;
            end
            // Low-word read data appears on its bank during ACC_HI.
            if (state == ACC_HI)
                lo_q <= lo_oor_q ? 15'd0 : bus.bank_rdata[int'(lo_bank_q)*15 +: 15];
            if (acc && cur_oor) addr_err <= 1'b1;
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.rdata_valid = rv_c;
    assign bus.rdata       = rdata_c;
    assign bus.bank_en     = en_c;
    assign bus.bank_we     = we_c;
    assign bus.bank_addr   = addr_c;
    assign bus.bank_wdata  = wdata_c;

`ifdef INT_RES_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++)
                if (bus.req[r] && !gnt_c[r] && stall_q[r*16 +: 16] != 16'hFFFF)
                    stall_q[r*16 +: 16] <= stall_q[r*16 +: 16] + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: doc/int_res_mem_arbiter.md
Name: int_res_mem_arbiter

Overview:
- Shares the 4-bank intermediate-result memory (4 × 14336 × 15b words, flat address space 0..57343) between NUM_REQ compute and control requesters using round-robin arbitration.
- Decodes each flat IntResAddr_t address into a bank select and a bank address.
- Splits DOUBLE_WIDTH accesses into two sequential single-word bank accesses: low half at address A, high half at A+1.
- Sits between the centralized controller/compute blocks and the int-res SRAM banks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BANK_WORDS, 14336, words per bank (CIM_INT_RES_BANK_SIZE_NUM_WORD).
- NUM_BANKS, 4, number of banks (CIM_INT_RES_NUM_BANKS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester access request; held with its fields until gnt.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_width  in  NUM_REQ  DataWidth_t: 0 = SINGLE_WIDTH, 1 = DOUBLE_WIDTH.
- req_addr  in  NUM_REQ*16  flat word address per requester.
- req_wdata  in  NUM_REQ*30  write data. SINGLE uses bits [14:0]; DOUBLE uses [14:0] → A and [29:15] → A+1.
- gnt  out  NUM_REQ  one-cycle grant pulse, one-hot.
- rdata_valid  out  NUM_REQ  one-cycle read-data-valid pulse to the owning requester.
- rdata  out  30  read data, shared by all requesters; valid only with rdata_valid. SINGLE reads are sign-extended to 30b.
- bank_en  out  NUM_BANKS  bank chip enable.
- bank_we  out  NUM_BANKS  bank write enable.
- bank_addr  out  NUM_BANKS*14  bank word address.
- bank_wdata  out  NUM_BANKS*15  bank write data.
- bank_rdata  in  NUM_BANKS*15  bank read data, one-cycle latency after bank_en with bank_we = 0.
- addr_err  out  1  sticky out-of-range flag; cleared only by rst.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. All outputs are 0: gnt, rdata_valid, rdata, bank_en, bank_we, bank_addr, bank_wdata, addr_err. The round-robin pointer is NUM_REQ-1, so requester 0 wins first.
- Reset mid-access: the access is abandoned. No rdata_valid is issued, and bank_en drops asynchronously.
- FSM states: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE:
  - If any req is set, the winner is the first asserted req scanning from pointer+1 modulo NUM_REQ.
  - The winner's we, width and addr/data are latched and the pointer is set to the winner.
  - Next state is ACC_LO. With no req, stay in IDLE.
- ACC_LO:
  - gnt[winner] = 1.
  - Drive one bank with the low word at address A: bank_en = 1, bank_we = latched we.
  - If DOUBLE, next state is ACC_HI. Otherwise next is RESP for a read, IDLE for a write.
- ACC_HI:
  - Drive the bank for address A+1 with the high word.
  - A+1 is re-decoded, so it may land in a different bank when A = k*BANK_WORDS-1.
  - Next state is RESP for a read, IDLE for a write.
- RESP (reads only):
  - Capture bank_rdata from the last-accessed bank into rdata; for DOUBLE, the low word was captured one cycle earlier.
  - rdata_valid[winner] = 1, then next state is IDLE.
- Address decode: combinational compares against 14336, 28672 and 43008; no division.
  - Bank = the number of thresholds the address is ≥ to.
  - Bank address = address minus the matching bank base.
- Out of range (any word address ≥ 57344, including A+1 = 57344):
  - No bank_en for that word and addr_err is set.
  - A read returns 0 for that half; the sequence and timing are unchanged.
- Latency from req sampled in IDLE at edge k:
  - gnt in cycle k+1.
  - SINGLE read: rdata_valid in cycle k+2.
  - DOUBLE read: rdata_valid in cycle k+3.
  - Writes complete at their last ACC cycle.
  - Minimum spacing between accesses is 2 cycles (SINGLE write) and 4 cycles (DOUBLE read).
- Requester rules:
  - A req dropped before gnt while still unserved is a protocol violation and is not detected.
  - A requester may reassert req the cycle after gnt; it loses to other waiting requesters because of the pointer.
- Only one bank_en bit may be high in any cycle.

Optional Feature:
- Macro: INT_RES_ARB_STATS_EN.
- With the macro:
  - Adds output stall_cnt (NUM_REQ*16).
  - Each requester has a 16-bit counter that increments in every cycle its req is high and it is not receiving gnt.
  - Counters saturate at 0xFFFF and reset to 0 on rst.
- Without the macro: no port, no counters; behaviour is otherwise identical.

Test Plan:
1. Requester 0: SINGLE write of 0x1234 to address 14336, then a SINGLE read of 14336 → bank_en[1] = 1 with bank_addr 0. rdata = 0x01234 (sign-extended 0x1234), with rdata_valid[0] 2 cycles after req.
2. Requester 2: DOUBLE write of 0x2AAA_5555 to 14335, then a DOUBLE read → low word to bank0 address 14335, high word to bank1 address 0. Readback = 0x2AAA5555, valid 3 cycles after req.
3. All 4 reqs held high → grants in order 0, 1, 2, 3, 0, each 2 cycles apart for SINGLE writes.
4. Read of address 57344, and a DOUBLE read of 57343 → no bank_en for the out-of-range word; that half of rdata is 0; addr_err = 1 and stays set.
5. rst asserted during ACC_HI of a DOUBLE read → bank_en falls immediately; no rdata_valid; first grant after reset goes to requester 0.
6. With INT_RES_ARB_STATS_EN, requesters 0 and 1 both request continuously for 10 cycles → stall counters match the stall cycles exactly; a forced counter value of 0xFFFF stays at 0xFFFF.
